// File: rtl/skew_feed_ctrl.sv
// Systolic skew feeder: accepts NumLanes-wide vectors and delays lane i by i extra cycles.
// Optional stall counter is built only when SKEW_FEED_STALL_CNT_EN is defined.
module skew_feed_ctrl #(
    parameter int NumLanes  = 4,
    parameter int DataWidth = 8,
    parameter int MaxLen    = 256
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic [$clog2(MaxLen+1)-1:0]     len_i,
    input  logic                            abort_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [NumLanes*DataWidth-1:0]   in_data_i,
    output logic [NumLanes-1:0]             out_valid_o,
    output logic [NumLanes*DataWidth-1:0]   out_data_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [31:0]                     stall_cnt_o
);

    localparam int LenW = $clog2(MaxLen + 1);
    localparam int DrnW = $clog2(NumLanes + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [LenW-1:0]   remain_q, remain_d;
    logic [DrnW-1:0]   drain_q, drain_d;
    logic              accept;

    // Handshake: a beat moves when in_valid_i && in_ready_o; in_ready_o depends on state only.
    assign accept     = in_valid_i && (state_q == FEED);
    assign in_ready_o = (state_q == FEED);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        drain_d  = drain_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        remain_d = len_i;
                        state_d  = FEED;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FEED: begin
                drain_d = '0;
                if (accept) remain_d = remain_q - LenW'(1);
                if (abort_i || (accept && remain_q == LenW'(1))) state_d = DRAIN;
            end
            DRAIN: begin
                drain_d = drain_q + DrnW'(1);
                if (drain_q == DrnW'(NumLanes - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            remain_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            drain_q  <= drain_d;
        end
    end

    // Lane l is an (l+1)-stage shift chain; injected data is zero on non-accepted cycles,
    // so an invalid output slot always carries zero data.
    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        localparam int St  = l + 1;
        localparam int StW = St * DataWidth;

        logic [St-1:0]        vld_q, vld_d;
        logic [StW-1:0]       dat_q, dat_d;
        logic [DataWidth-1:0] inj;

        assign inj = accept ? in_data_i[l*DataWidth +: DataWidth] : '0;

        always_comb begin
            vld_d = St'({vld_q, accept});
            dat_d = StW'({dat_q, inj});
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign out_valid_o[l]                        = vld_q[l];
        assign out_data_o[l*DataWidth +: DataWidth]  = dat_q[l*DataWidth +: DataWidth];
    end

`ifdef SKEW_FEED_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start_i) begin
            stall_d = '0;
        end else if (state_q == FEED && !in_valid_i && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/skew_feed_ctrl.md
SKEW_FEED_CTRL -- requirements
Module: skew_feed_ctrl

Interface
REQ-001 The module SHALL have parameter NumLanes, default 4, giving the number of systolic input lanes (legal range 2..16).
REQ-002 The module SHALL have parameter DataWidth, default 8, giving the operand width per lane.
REQ-003 The module SHALL have parameter MaxLen, default 256, giving the maximum number of vectors per job.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port start_i, input, 1 bit: job start request, sampled only in IDLE.
REQ-007 The module SHALL have port len_i, input, $clog2(MaxLen+1) bits: vector count for the job, sampled with start_i.
REQ-008 The module SHALL have port abort_i, input, 1 bit: ends FEED early.
REQ-009 The module SHALL have port in_valid_i, input, 1 bit: the input vector is valid.
REQ-010 The module SHALL have port in_ready_o, output, 1 bit: the controller accepts a vector.
REQ-011 The module SHALL have port in_data_i, input, NumLanes*DataWidth bits: lane i occupies bits [i*DataWidth +: DataWidth].
REQ-012 The module SHALL have port out_valid_o, output, NumLanes bits: per-lane skewed valid.
REQ-013 The module SHALL have port out_data_o, output, NumLanes*DataWidth bits: per-lane skewed data.
REQ-014 The module SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-015 The module SHALL have port done_o, output, 1 bit: one-cycle job-complete pulse.
REQ-016 The module SHALL have port stall_cnt_o, output, 32 bits: count of FEED cycles with in_valid_i low (see Configuration).

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, FEED, DRAIN and DONE.
REQ-018 From IDLE, start_i=1 with len_i>0 SHALL load the remaining-vector counter with len_i and enter FEED.
REQ-019 From IDLE, start_i=1 with len_i=0 SHALL enter DONE directly.
REQ-020 start_i SHALL be ignored in every state other than IDLE.
REQ-021 in_ready_o SHALL equal (state==FEED), with no combinational path from in_valid_i.
REQ-022 A beat SHALL be accepted only when in_valid_i and in_ready_o are both high; each accepted beat decrements the remaining-vector counter.
REQ-023 Accepting the final beat (counter==1) SHALL move FEED to DRAIN.
REQ-024 abort_i=1 in FEED SHALL move to DRAIN; a beat accepted in the same cycle is still injected, and abort_i is ignored in all other states.
REQ-025 DRAIN SHALL last exactly NumLanes cycles, then go to DONE.
REQ-026 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-027 Each cycle, every lane i SHALL shift through a (i+1)-stage register chain.
REQ-028 The value injected into each lane chain SHALL be {valid=1, data=lane slice} on an accepted beat, otherwise {valid=0, data=0}.
REQ-029 An accepted beat at edge E SHALL cause lane i to present its data on out_valid_o[i] and out_data_o in the cycle following edge E+i.
REQ-030 A lane whose out_valid_o is 0 SHALL drive 0 on its out_data_o slice.
REQ-031 In-FEED bubbles (in_valid_i=0) SHALL propagate as aligned zero-valid slots in all lanes.
REQ-032 The skew chains SHALL shift continuously in every state.

Reset
REQ-033 rst_ni=0 SHALL asynchronously force state IDLE, all chain registers 0, counters 0, out_valid_o=0, out_data_o=0, in_ready_o=0, busy_o=0, done_o=0 and stall_cnt_o=0.
REQ-034 A reset asserted mid-job SHALL discard all in-flight data with no done_o pulse, and the module SHALL wait for a new start_i.

Configuration
REQ-035 With macro SKEW_FEED_STALL_CNT_EN defined, stall_cnt_o SHALL increment, saturating at 2^32-1, in each FEED cycle with in_valid_i=0, and SHALL clear on each accepted start_i.
REQ-036 Without SKEW_FEED_STALL_CNT_EN, stall_cnt_o SHALL be tied to 0 and no counter logic shall exist.

Verification
REQ-037 NumLanes=4, start with len=3, three back-to-back beats 0x04030201, 0x08070605, 0x0C0B0A09 -> lane 0 shows 01,05,09 on cycles 1-3 after acceptance and lane 3 shows 04,08,0C three cycles later; done_o pulses 5 cycles after the last beat and busy_o is high throughout.
REQ-038 len=4 with in_valid_i low for 2 cycles between beats 2 and 3 -> a 2-slot zero-valid gap appears in all lanes at the skewed positions; stall_cnt_o=2 with the macro defined, 0 without.
REQ-039 start with len=0 -> busy_o high 1 cycle, done_o pulses the next cycle, out_valid_o stays 0.
REQ-040 len=10 with abort_i after 2 accepted beats -> in_ready_o drops the next cycle, exactly 2 valid slots per lane, and done_o pulses NumLanes+1 cycles after the abort.
REQ-041 rst_ni pulsed low during DRAIN -> all outputs 0 immediately, no done_o; a following start with len=1 completes normally.
REQ-042 start_i asserted during FEED with a different len_i -> ignored, and the original job completes with the original length.
